// File: rtl/ks_sched_pkg.sv
// ks_sched_pkg: shared types and defaults for the chunked Kogge-Stone add
// scheduler (FSM state encoding, default geometry, requester-id width).
package ks_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int CW_DEF    = 16;
  localparam int WORDS_DEF = 4;
  localparam int ID_W      = 1;

  // Width of a counter that walks n chunks (at least one bit).
  function automatic int chunk_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ks_add_scheduler_if.sv
// ks_add_scheduler_if: two add requesters plus one result consumer.
// master = requester/consumer side, slave = scheduler side.
interface ks_add_scheduler_if
  import ks_sched_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int WORDS = WORDS_DEF
) ();

  localparam int W = CW * WORDS;

  logic            req0_valid;
  logic            req0_ready;
  logic [W-1:0]    req0_a;
  logic [W-1:0]    req0_b;
  logic            req0_cin;

  logic            req1_valid;
  logic            req1_ready;
  logic [W-1:0]    req1_a;
  logic [W-1:0]    req1_b;
  logic            req1_cin;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic [ID_W-1:0] rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

endinterface

// File: rtl/kogge_stone_4bit.sv
// kogge_stone_4bit: combinational Kogge-Stone parallel-prefix adder of
// width bw. The carry-in is folded in as an extra generate bit below bit 0,
// so the prefix network delivers every carry, including cout, directly.
module kogge_stone_4bit #(
  parameter int bw = 4
) (
  input  logic [bw-1:0] a,
  input  logic [bw-1:0] b,
  input  logic          cin,
  output logic [bw-1:0] sum,
  output logic          cout
);

  localparam int N = bw + 1;

  logic [N-1:0] gc;
  logic [N-1:0] pc;
  logic [N-1:0] gn;
  logic [N-1:0] pn;

  // Prefix levels with doubling span; after the last level gc[j] is the
  // carry out of position j-1 (gc[0] being the carry-in itself).
  always_comb begin
    gc = {a & b, cin};
    pc = {a ^ b, 1'b0};
    gn = gc;
    pn = pc;
    for (int d = 1; d < N; d = d * 2) begin
      gn = gc;
      pn = pc;
      for (int j = d; j < N; j++) begin
        gn[j] = gc[j] | (pc[j] & gc[j-d]);
        pn[j] = pc[j] & pc[j-d];
      end
      gc = gn;
      pc = pn;
    end
    sum  = (a ^ b) ^ gc[bw-1:0];
    cout = gc[bw];
  end

endmodule

// File: rtl/ks_arb2.sv
// ks_arb2: two-way grant for the add scheduler. Grants are one-hot (or
// zero) and only ever name a requester whose valid is high.
// Build option: define KS_SCHED_RR_EN for round-robin; otherwise fixed
// priority with requester 0 winning ties and no pointer state at all.
module ks_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef KS_SCHED_RR_EN
  // Requester granted most recently; reset to 1 so requester 0 wins first.
  logic last;

  // Pointer moves only when a grant is actually accepted.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    if (rst)         last <= 1'b1;
    else if (accept) last <= grant[1];
  end

  // Ties go to whichever requester was not granted last.
  always_comb begin
    // NOTE: default assigned first so no path leaves grant unassigned (no latch).
    grant = valid;
    if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, accept};

  // Fixed priority: requester 0 always wins a tie.
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0];
    grant[1] = valid[1] & ~valid[0];
  end
`endif

endmodule

// File: rtl/ks_add_scheduler.sv
// ks_add_scheduler: time-shares one CW-bit Kogge-Stone adder to add two
// WORDS*CW-bit operands chunk by chunk, serving two requesters.
// Accept (IDLE) -> WORDS chunk cycles (RUN) -> hold result (DONE).
// Build option: KS_SCHED_RR_EN selects round-robin arbitration in ks_arb2.
module ks_add_scheduler
  import ks_sched_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input logic               clk,
  input logic               rst,
  ks_add_scheduler_if.slave bus
);

  localparam int KW = chunk_idx_w(WORDS);
  localparam int W  = CW * WORDS;
  localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);

  sched_state_t state;
  sched_state_t state_n;

  logic [KW-1:0]             k;
  logic                      carry;
  logic [WORDS-1:0][CW-1:0]  a_r;
  logic [WORDS-1:0][CW-1:0]  b_r;
  logic [WORDS-1:0][CW-1:0]  sum_r;
  logic                      cout_r;
  logic [ID_W-1:0]           id_r;

  logic [1:0]    grant;
  logic [1:0]    rdy;
  logic          accept;
  logic          rsp_vld;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic          sel_cin;
  logic [CW-1:0] chunk_sum;
  logic          chunk_cout;

  ks_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  kogge_stone_4bit #(.bw(CW)) u_add (
    .a    (a_r[k]),
    .b    (b_r[k]),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Operand mux: the granted requester's inputs.
  always_comb begin
    sel_a   = bus.req0_a;
    sel_b   = bus.req0_b;
    sel_cin = bus.req0_cin;
    if (grant[1]) begin
      sel_a   = bus.req1_a;
      sel_b   = bus.req1_b;
      sel_cin = bus.req1_cin;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next state and handshake outputs; nothing is offered during reset.
  always_comb begin
    state_n = state;
    rdy     = 2'b00;
    accept  = 1'b0;
    rsp_vld = 1'b0;
    case (state)
      IDLE: begin
        rdy    = rst ? 2'b00 : grant;
        accept = |rdy;
        if (accept) state_n = RUN;
      end
      RUN: begin
        if (k == LAST_K) state_n = DONE;
      end
      DONE: begin
        rsp_vld = ~rst;
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: operand registers have no reset; they are always loaded on acceptance before being read.
    if (accept) begin
      a_r <= sel_a;
      b_r <= sel_b;
    end
  end

  // Chunk walk: one chunk per RUN cycle, carry chained through the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      id_r   <= '0;
    end else if (accept) begin
      k     <= '0;
      carry <= sel_cin;
      id_r  <= ID_W'(grant[1]);
    end else if (state == RUN) begin
      sum_r[k] <= chunk_sum;
      carry    <= chunk_cout;
      if (k == LAST_K) begin
        k      <= '0;
        cout_r <= chunk_cout;
      end else begin
        k <= k + KW'(1);
      end
    end
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_sum    = sum_r;
  assign bus.rsp_cout   = cout_r;
  assign bus.rsp_id     = id_r;

endmodule

// File: tb/tb_ks_add_scheduler.sv
// tb_ks_add_scheduler: directed and randomized checks of ks_add_scheduler
// against a transaction-level model (a+b+cin, latency rule, arbitration).
module tb_ks_add_scheduler;

  localparam int CW    = 16;
  localparam int WORDS = 4;
  localparam int W     = CW * WORDS;

  typedef logic [W:0] val_t;
  typedef struct {
    logic id;
    val_t res;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         cons_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // model state
  exp_t q[$];
  int   grants[$];
  bit   busy = 0;
  logic last_id = 1'b1;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_rsp = 0;
  bit   acc0 = 0, acc1 = 0, got_rsp = 0;
  int   last_lat = 0;
  val_t last_res = '0;
  logic last_rsp_id = 1'b0;

  ks_add_scheduler_if #(.CW(CW), .WORDS(WORDS)) bus ();

  ks_add_scheduler #(.CW(CW), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req0_valid = v0;
  assign bus.req0_a     = a0;
  assign bus.req0_b     = b0;
  assign bus.req0_cin   = c0;
  assign bus.req1_valid = v1;
  assign bus.req1_a     = a1;
  assign bus.req1_b     = b1;
  assign bus.req1_cin   = c1;
  assign bus.rsp_ready  = cons_ready;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  task automatic check(input string tag, input val_t got, input val_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    return {$urandom, $urandom};
  endfunction

  function automatic val_t model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
    return val_t'(a) + val_t'(b) + val_t'(c);
  endfunction

  // One clock cycle: compare outputs at the falling edge, advance the model,
  // then return just after the next rising edge.
  task automatic cycle();
    logic [1:0] exp_rdy;
    logic       exp_vld;
    logic       prefer1;
    acc0    = 0;
    acc1    = 0;
    got_rsp = 0;
    @(negedge clk);
`ifdef KS_SCHED_RR_EN
    prefer1 = (last_id == 1'b0);
`else
    prefer1 = 1'b0;
`endif
    exp_rdy = 2'b00;
    if (!rst && !busy) begin
      if (v0 && v1) exp_rdy = prefer1 ? 2'b10 : 2'b01;
      else          exp_rdy = {v1, v0};
    end
    check("ready", val_t'({bus.req1_ready, bus.req0_ready}), val_t'(exp_rdy));
    exp_vld = !rst && busy && (cyc - acc_cyc >= WORDS + 1);
    check("rsp_valid", val_t'(bus.rsp_valid), val_t'(exp_vld));
    if (exp_vld && q.size() > 0) begin
      check("rsp_data", {bus.rsp_cout, bus.rsp_sum}, q[0].res);
      check("rsp_id", val_t'(bus.rsp_id), val_t'(q[0].id));
    end
    if (rst) begin
      busy    = 0;
      q.delete();
      last_id = 1'b1;
    end else begin
      if (bus.rsp_valid && cons_ready) begin
        got_rsp     = 1;
        n_rsp++;
        last_lat    = cyc - acc_cyc;
        last_res    = {bus.rsp_cout, bus.rsp_sum};
        last_rsp_id = bus.rsp_id[0];
        if (q.size() > 0) void'(q.pop_front());
        busy = 0;
      end
      if (v0 && bus.req0_ready) begin
        q.push_back('{id: 1'b0, res: model_add(a0, b0, c0)});
        busy = 1; acc_cyc = cyc; last_id = 1'b0; acc0 = 1;
        grants.push_back(0);
      end
      if (v1 && bus.req1_ready) begin
        q.push_back('{id: 1'b1, res: model_add(a1, b1, c1)});
        busy = 1; acc_cyc = cyc; last_id = 1'b1; acc1 = 1;
        grants.push_back(1);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, val_t'(bus.rsp_valid), '0);
    check({tag, "_sum"}, {bus.rsp_cout, bus.rsp_sum}, '0);
    check({tag, "_id"}, val_t'(bus.rsp_id), '0);
  endtask

  // Present one operation on a requester, wait for acceptance, drop valid.
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    int  n = 0;
    bit  done = 0;
    if (id) begin v1 = 1'b1; a1 = a; b1 = b; c1 = c; end
    else    begin v0 = 1'b1; a0 = a; b0 = b; c0 = c; end
    while (!done && n < 20) begin
      cycle();
      done = id ? acc1 : acc0;
      n++;
    end
    check("accept_timeout", val_t'(done), val_t'(1));
    if (id) v1 = 1'b0;
    else    v0 = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!got_rsp && n < limit);
    check("rsp_timeout", val_t'(got_rsp), val_t'(1));
  endtask

  initial begin
    int   n;
    int   start;
    val_t exp_val;

    // reset with both requesters asking: nothing may be accepted
    v0 = 1'b1; v1 = 1'b1; a0 = rand_word(); b0 = rand_word(); a1 = rand_word();
    do_reset(3);
    v0 = 1'b0; v1 = 1'b0;
    check_reset_outputs("reset");

    // single op, carry out of chunk 0 into chunk 1
    cons_ready = 1'b1;
    issue(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_rsp(20);
    check("single_lat", val_t'(last_lat), val_t'(WORDS + 1));
    check("single_sum", last_res, val_t'(65'h0_0000_0000_0001_0000));
    check("single_id", val_t'(last_rsp_id), val_t'(0));

    // full carry ripple across every chunk
    issue(1'b1, '1, '0, 1'b1);
    wait_rsp(20);
    check("ripple_sum", last_res, val_t'(1) << W);
    check("ripple_id", val_t'(last_rsp_id), val_t'(1));

    // both valid continuously: arbitration order
    do_reset(2);
    cons_ready = 1'b1;
    grants.delete();
    v0 = 1'b1; a0 = rand_word(); b0 = rand_word(); c0 = 1'($urandom_range(0, 1));
    v1 = 1'b1; a1 = rand_word(); b1 = rand_word(); c1 = 1'($urandom_range(0, 1));
    start = n_rsp;
    n = 0;
    while (n_rsp - start < 8 && n < 200) begin
      cycle();
      if (acc0) begin a0 = rand_word(); b0 = rand_word(); c0 = 1'($urandom_range(0, 1)); end
      if (acc1) begin a1 = rand_word(); b1 = rand_word(); c1 = 1'($urandom_range(0, 1)); end
      n++;
    end
    v0 = 1'b0; v1 = 1'b0;
    check("arb_count", val_t'(n_rsp - start), val_t'(8));
`ifdef KS_SCHED_RR_EN
    for (int i = 0; i < 8 && i < grants.size(); i++)
      check("rr_order", val_t'(grants[i]), val_t'(i % 2));
`else
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("fixed_order", val_t'(grants[i]), val_t'(0));
`endif

    // backpressure: hold in DONE for 10 cycles with both requesters waiting
    do_reset(2);
    cons_ready = 1'b0;
    a0 = rand_word(); b0 = rand_word();
    exp_val = model_add(a0, b0, 1'b1);
    issue(1'b0, a0, b0, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      cycle();
      n++;
    end
    check("bp_reach_done", val_t'(bus.rsp_valid), val_t'(1));
    v0 = 1'b1; v1 = 1'b1;
    a0 = rand_word(); b0 = rand_word(); a1 = rand_word(); b1 = rand_word();
    repeat (10) begin
      cycle();
      check("bp_valid", val_t'(bus.rsp_valid), val_t'(1));
      check("bp_hold", {bus.rsp_cout, bus.rsp_sum}, exp_val);
      check("bp_readys", val_t'({bus.req1_ready, bus.req0_ready}), '0);
    end
    cons_ready = 1'b1;
    cycle();
    check("bp_release", val_t'(bus.req0_ready | bus.req1_ready), val_t'(1));
    v0 = 1'b0; v1 = 1'b0;
    cycle();

    // reset in the second RUN cycle discards the operation
    do_reset(2);
    cons_ready = 1'b1;
    issue(1'b0, rand_word(), rand_word(), 1'b1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    start = n_rsp;
    repeat (10) cycle();
    check("rst_no_rsp", val_t'(n_rsp - start), '0);
    check_reset_outputs("rst_mid");
    a1 = rand_word(); b1 = rand_word();
    exp_val = model_add(a1, b1, 1'b0);
    issue(1'b1, a1, b1, 1'b0);
    wait_rsp(20);
    check("post_rst_sum", last_res, exp_val);
    check("post_rst_id", val_t'(last_rsp_id), val_t'(1));

    // randomized traffic, dropped requests and backpressure
    do_reset(2);
    start = n_rsp;
    n = 0;
    while (n_rsp - start < 1000 && n < 40000) begin
      if (acc0 || !v0) begin
        v0 = ($urandom_range(0, 99) < 55);
        a0 = rand_word(); b0 = rand_word(); c0 = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 99) < 8) begin
        v0 = 1'b0;
      end
      if (acc1 || !v1) begin
        v1 = ($urandom_range(0, 99) < 55);
        a1 = rand_word(); b1 = rand_word(); c1 = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 99) < 8) begin
        v1 = 1'b0;
      end
      cons_ready = ($urandom_range(0, 99) < 65);
      cycle();
      n++;
    end
    check("random_count", val_t'(n_rsp - start), val_t'(1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
